// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: run-control state encoding and the EBREAK instruction word
package core_ctrl_pkg;
  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } run_state_t;
  localparam logic [31:0] EBREAK = 32'h00100073;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer + rising-edge detect for a raw pushbutton
//   clk, rst (async, active-low), btn (raw async input) -> pulse (one clock wide)
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic s1, s2, s3;
  // s1/s2 synchronize; s3 holds the previous synchronized level; pulse is registered
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s2, s3, pulse} <= '0;
    else {s1, s2, s3, pulse} <= {btn, s1, s2, s2 & ~s3};
endmodule

// File: rtl/core_run_control.sv
// core_run_control: HALT/RUN/STEP/BREAK run control with clock divider, breakpoint and counters
//   in : clk, rst (async, active-low), run_sw, step_btn, halt_req, bp_en, bp_addr, pc, instr, cnt_clr
//   out: core_en, state, bp_hit, cycle_count, instr_count
module core_run_control
  import core_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV     = 1,
  parameter bit          EBREAK_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        cnt_clr,
  output logic        core_en,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);
  localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  run_state_t cur, nxt;
  logic [DW-1:0] div;
  logic skip, step_pulse, stop, brk, term;
  btn_sync_edge u_step (.clk(clk), .rst(rst), .btn(step_btn), .pulse(step_pulse));
  assign stop = halt_req | ~run_sw;
  // skip masks only the address breakpoint so a resume at the breakpoint PC executes it once
  assign brk = (bp_en && pc == bp_addr && !skip) || (EBREAK_HALT && instr == EBREAK);
  assign term = div == DW'(RUN_DIV - 1);
  always_comb begin
    nxt = cur;
    case (cur)
      HALT:  nxt = (run_sw && !halt_req) ? RUN : (step_pulse && !run_sw) ? STEP : HALT;
      RUN:   nxt = stop ? HALT : brk ? BREAK : RUN;
      STEP:  nxt = HALT;
      BREAK: nxt = !run_sw ? HALT : step_pulse ? STEP : BREAK;
    endcase
  end
  // staying in RUN implies no stop condition this cycle
  assign core_en = (cur == RUN && term && nxt == RUN) || cur == STEP;
  assign state = cur;
  assign bp_hit = cur == BREAK;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur <= HALT;
      div <= '0;
      skip <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      div <= (cur != RUN || term) ? '0 : div + 1'b1;
      skip <= (cur == BREAK && nxt != BREAK) ? 1'b1 : core_en ? 1'b0 : skip;
      cycle_count <= cnt_clr ? '0 : (cur == RUN && ~&cycle_count) ? cycle_count + 1'b1 : cycle_count;
      instr_count <= cnt_clr ? '0 : (core_en && ~&instr_count) ? instr_count + 1'b1 : instr_count;
    end
endmodule
